// File: rtl/controlador_batalha_param.sv
// Battleship game controller, parametrised grid / attack budget / blink rate.
// Tracks hit and miss history, remaining attempts, hit count and the win/lose
// end states, and drives a blink-encoded board to the matrix scanner.
//
// Ports:
//   clock, reset              scan clock, synchronous active-high reset
//   ligado                    power switch (0 forces DESLIGADO)
//   modo                      0 = positioning, 1 = attack
//   salvar_jogo               pulse: latch the placement board
//   confirmar_ataque          pulse: fire at (ataque_coluna, ataque_linha)
//   tabuleiro_posicionamento  live placement board, bit = col*LINHAS+row
//   tabuleiro_saida           registered display board, same indexing
//   estado                    state code (0..5)
//   tentativas_restantes      attacks left
//   acertos                   distinct ship cells hit
//   fim_jogo                  high in VITORIA or DERROTA
module controlador_batalha_param #(
  parameter int unsigned COLUNAS        = 5,
  parameter int unsigned LINHAS         = 7,
  parameter int unsigned MAX_TENTATIVAS = 10,
  parameter int unsigned BLINK_DIV      = 95,
  localparam int unsigned N  = COLUNAS * LINHAS,
  localparam int unsigned WC = (COLUNAS > 1) ? $clog2(COLUNAS) : 1,
  localparam int unsigned WL = (LINHAS > 1) ? $clog2(LINHAS) : 1,
  localparam int unsigned WT = $clog2(MAX_TENTATIVAS + 1),
  localparam int unsigned WA = $clog2(N + 1)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          ligado,
  input  logic          modo,
  input  logic          salvar_jogo,
  input  logic          confirmar_ataque,
  input  logic [WC-1:0] ataque_coluna,
  input  logic [WL-1:0] ataque_linha,
  input  logic [N-1:0]  tabuleiro_posicionamento,
  output logic [N-1:0]  tabuleiro_saida,
  output logic [2:0]    estado,
  output logic [WT-1:0] tentativas_restantes,
  output logic [WA-1:0] acertos,
  output logic          fim_jogo
);

  localparam int unsigned WB = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int unsigned WI = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [2:0] {
    StDesligado      = 3'd0,
    StPosicionamento = 3'd1,
    StSalvo          = 3'd2,
    StAtaque         = 3'd3,
    StVitoria        = 3'd4,
    StDerrota        = 3'd5
  } estado_t;

  estado_t       r_estado, w_estado_d;
  logic [N-1:0]  r_salvo, w_salvo_d;
  logic [N-1:0]  r_hit, w_hit_d;
  logic [N-1:0]  r_miss, w_miss_d;
  logic [N-1:0]  r_saida, w_saida_d;
  logic [WT-1:0] r_tent, w_tent_d;
  logic [WA-1:0] r_acertos, w_acertos_d;
  logic [WA-1:0] r_total, w_total_d;
  logic [WB-1:0] r_cnt, w_cnt_d;
  logic          r_fase, w_fase_d;

  logic [WA-1:0] w_pop;
  logic          w_valido;
  logic [WI-1:0] w_idx;
  logic [N-1:0]  w_sel;
  logic          w_ja_atacado;
  logic          w_navio;

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < int'(N); i++) begin
      w_pop = w_pop + WA'(tabuleiro_posicionamento[i]);
    end
  end

  // One-hot target cell; all-zero when the coordinate is off the grid.
  always_comb begin
    w_valido = (32'(ataque_coluna) < COLUNAS) && (32'(ataque_linha) < LINHAS);
    w_idx    = WI'(32'(ataque_coluna) * LINHAS + 32'(ataque_linha));
    w_sel    = w_valido ? (N'(1) << w_idx) : '0;
  end

  assign w_ja_atacado = |(w_sel & (r_hit | r_miss));
  assign w_navio      = |(w_sel & r_salvo);

  always_comb begin
    w_estado_d  = r_estado;
    w_salvo_d   = r_salvo;
    w_hit_d     = r_hit;
    w_miss_d    = r_miss;
    w_tent_d    = r_tent;
    w_acertos_d = r_acertos;
    w_total_d   = r_total;

    if (!ligado) begin
      w_estado_d  = StDesligado;
      w_hit_d     = '0;
      w_miss_d    = '0;
      w_tent_d    = WT'(MAX_TENTATIVAS);
      w_acertos_d = '0;
    end else begin
      unique case (r_estado)
        StDesligado: w_estado_d = StPosicionamento;
        StPosicionamento: begin
          if (salvar_jogo && (w_pop != '0)) begin
            w_salvo_d  = tabuleiro_posicionamento;
            w_total_d  = w_pop;
            w_estado_d = StSalvo;
          end
        end
        StSalvo: begin
          if (salvar_jogo && (w_pop != '0)) begin
            w_salvo_d = tabuleiro_posicionamento;
            w_total_d = w_pop;
          end
          if (modo) begin
            w_estado_d  = StAtaque;
            w_hit_d     = '0;
            w_miss_d    = '0;
            w_tent_d    = WT'(MAX_TENTATIVAS);
            w_acertos_d = '0;
          end
        end
        StAtaque: begin
          if (!modo) begin
            w_estado_d  = StPosicionamento;
            w_hit_d     = '0;
            w_miss_d    = '0;
            w_tent_d    = WT'(MAX_TENTATIVAS);
            w_acertos_d = '0;
          end else begin
            if (confirmar_ataque && (w_sel != '0) && !w_ja_atacado) begin
              if (w_navio) begin
                w_hit_d = r_hit | w_sel;
                if (r_acertos < r_total) w_acertos_d = r_acertos + 1'b1;
              end else begin
                w_miss_d = r_miss | w_sel;
              end
              if (r_tent != '0) w_tent_d = r_tent - 1'b1;
            end
            // Victory is checked first so a winning last shot never loses.
            if (w_acertos_d == r_total)  w_estado_d = StVitoria;
            else if (w_tent_d == '0)     w_estado_d = StDerrota;
          end
        end
        StVitoria, StDerrota: begin
          if (!modo) begin
            w_estado_d  = StPosicionamento;
            w_hit_d     = '0;
            w_miss_d    = '0;
            w_tent_d    = WT'(MAX_TENTATIVAS);
            w_acertos_d = '0;
          end
        end
        default: w_estado_d = StDesligado;
      endcase
    end
  end

  // Blink phase is parked at zero while powered down.
  always_comb begin
    w_cnt_d  = '0;
    w_fase_d = 1'b0;
    if (w_estado_d != StDesligado) begin
      if (r_cnt == WB'(BLINK_DIV - 1)) begin
        w_cnt_d  = '0;
        w_fase_d = ~r_fase;
      end else begin
        w_cnt_d  = r_cnt + 1'b1;
        w_fase_d = r_fase;
      end
    end
  end

  // Display is built from next-state values so it lines up with estado.
  always_comb begin
    w_saida_d = '0;
    unique case (w_estado_d)
      StDesligado:      w_saida_d = '0;
      StPosicionamento: w_saida_d = tabuleiro_posicionamento;
      StSalvo:          w_saida_d = w_salvo_d;
      StAtaque:         w_saida_d = w_hit_d | (w_miss_d & {N{w_fase_d}});
      StVitoria:        w_saida_d = w_salvo_d;
      StDerrota:        w_saida_d = w_salvo_d & {N{w_fase_d}};
      default:          w_saida_d = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado  <= StDesligado;
      r_salvo   <= '0;
      r_hit     <= '0;
      r_miss    <= '0;
      r_saida   <= '0;
      r_tent    <= WT'(MAX_TENTATIVAS);
      r_acertos <= '0;
      r_total   <= '0;
      r_cnt     <= '0;
      r_fase    <= 1'b0;
    end else begin
      r_estado  <= w_estado_d;
      r_salvo   <= w_salvo_d;
      r_hit     <= w_hit_d;
      r_miss    <= w_miss_d;
      r_saida   <= w_saida_d;
      r_tent    <= w_tent_d;
      r_acertos <= w_acertos_d;
      r_total   <= w_total_d;
      r_cnt     <= w_cnt_d;
      r_fase    <= w_fase_d;
    end
  end

  assign tabuleiro_saida      = r_saida;
  assign estado               = r_estado;
  assign tentativas_restantes = r_tent;
  assign acertos              = r_acertos;
  assign fim_jogo             = (r_estado == StVitoria) || (r_estado == StDerrota);

endmodule

// File: doc/controlador_batalha_param.md
Name: controlador_batalha_param

Overview:
- Parametrised successor to the fixed 5x7 battleship game controller.
- Grid size, attack budget and blink rate are generic.
- Tracks per-cell hit/miss history, remaining attempts, hit count and win/lose end states, and produces a blink-encoded display board for the matrix scanner.
- Sits between the debounced button pulses / board-select logic and the matrix driver, in the 381 Hz clock domain.

Parameters:
- COLUNAS, 5, number of grid columns.
- LINHAS, 7, number of grid rows.
- MAX_TENTATIVAS, 10, attacks allowed per game (1..255).
- BLINK_DIV, 95, clock cycles per blink half-period (>=1).

Ports:
- clock  in  1  system clock (381 Hz scan clock).
- reset  in  1  synchronous, active-high reset.
- ligado  in  1  game power switch; 0 forces DESLIGADO.
- modo  in  1  0 = positioning, 1 = attack.
- salvar_jogo  in  1  one-cycle pulse, latch the placement board.
- confirmar_ataque  in  1  one-cycle pulse, fire at the selected cell.
- ataque_coluna  in  $clog2(COLUNAS)  target column.
- ataque_linha  in  $clog2(LINHAS)  target row.
- tabuleiro_posicionamento  in  COLUNAS*LINHAS  live placement board; bit index = col*LINHAS+row.
- tabuleiro_saida  out  COLUNAS*LINHAS  display board, same indexing.
- estado  out  3  current state code.
- tentativas_restantes  out  $clog2(MAX_TENTATIVAS+1)  attacks left.
- acertos  out  $clog2(COLUNAS*LINHAS+1)  distinct ship cells hit.
- fim_jogo  out  1  high in VITORIA or DERROTA.

Behaviour:
- Reset values:
  - Clock and reset follow the decided scheme: one clock, synchronous active-high reset.
  - On reset: estado=DESLIGADO(0), tabuleiro_saida=0, tentativas_restantes=MAX_TENTATIVAS, acertos=0, fim_jogo=0.
  - Also cleared on reset: saved board, hit mask, miss mask, blink counter and blink phase.
- State codes: DESLIGADO=0, POSICIONAMENTO=1, SALVO=2, ATAQUE=3, VITORIA=4, DERROTA=5.
- Priority order: reset > ligado=0 > all other transitions.
- Transitions and state actions:
  - Any state with ligado=0: next cycle DESLIGADO; masks and counters cleared.
  - DESLIGADO, ligado=1: go to POSICIONAMENTO.
  - POSICIONAMENTO, salvar_jogo pulse: latch tabuleiro_posicionamento; total_navios = popcount of the latched board; go to SALVO. If popcount = 0, the save is rejected and the state stays POSICIONAMENTO.
  - SALVO, modo=1: go to ATAQUE; tentativas reloaded to MAX_TENTATIVAS, acertos=0, masks cleared.
  - SALVO, modo=0: stay in SALVO. A further salvar_jogo re-latches the board.
  - ATAQUE, confirmar_ataque pulse with in-range coordinates on a cell never attacked before:
    - ship cell: set its hit bit and increment acertos;
    - empty cell: set its miss bit;
    - either way, decrement tentativas.
  - ATAQUE attacks that have no effect (no change to any counter or mask):
    - repeated attack on an already-attacked cell;
    - coordinate out of range (col >= COLUNAS or row >= LINHAS).
  - End of game: evaluated on post-update values in the same cycle.
    - acertos == total_navios: go to VITORIA.
    - Else tentativas == 0: go to DERROTA.
    - Victory wins if both conditions become true on the final attack.
  - ATAQUE, modo=0: back to POSICIONAMENTO; masks and counters reset (new game).
  - VITORIA/DERROTA: hold until modo=0 (go to POSICIONAMENTO) or ligado=0.
- Input gating: confirmar_ataque is ignored outside ATAQUE; salvar_jogo is ignored outside POSICIONAMENTO/SALVO. A simultaneous salvar+confirmar in ATAQUE processes only the attack.
- Latency: every input pulse is reflected in the registered outputs on the next clock edge.
- Blink generator:
  - Counter runs 0..BLINK_DIV-1; fase toggles on wrap.
  - Free-running in every state except DESLIGADO, where it is held at 0.
- tabuleiro_saida, registered, per state:
  - DESLIGADO: 0.
  - POSICIONAMENTO: tabuleiro_posicionamento.
  - SALVO: saved board.
  - ATAQUE: hit | (miss & {fase}).
  - VITORIA: saved board (solid).
  - DERROTA: saved board & {fase}.
- Width rules: counters never underflow or overflow; tentativas saturates at 0 and acertos never exceeds total_navios.

Test Plan:
- Default params, reset, then ligado=1 → estado=1 one cycle later. Load board 0x00000007, salvar pulse → estado=2 and tabuleiro_saida=0x7.
- From SALVO with board 0x7, modo=1, then attack (0,0),(0,1),(0,2) → acertos 1,2,3; tentativas 9,8,7; estado=4 on the cycle after the third attack; fim_jogo=1.
- Board 0x1, 10 attacks at empty cells (0,1)..(1,3) → tentativas reaches 0, estado=5. With BLINK_DIV=4, tabuleiro_saida alternates 0x1/0x0 every 4 cycles.
- Repeated attack on (0,1) and out-of-range attack (5,0) → tentativas and acertos unchanged. An earlier miss at (0,1) blinks: bit 1 follows fase while the hit bits stay steady.
- Board 0x2 with the last attempt hitting the last ship (tentativas 1→0) → estado=4, not 5.
- Reset or ligado=0 mid-ATAQUE → next cycle estado=0, tabuleiro_saida=0, tentativas=10, acertos=0. A salvar pulse with an all-zero board → stays in estado=1.
